vend_dispenser: RTL and testbench

//  Output side of the vending machine: accepts one vend transaction (inserted credit) per

---
 rtl/vend_dispenser.sv | 211 +++++++++++++++++++++
 tb/tb_vend_dispenser.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/vend_dispenser.sv
// vend_dispenser
// Output side of the vending machine. Accepts one vend transaction (credit in nickel
// units) per valid/ready handshake, releases the product when credit covers the price,
// then pays the balance back as dime/nickel ejects. Each actuator request is held until
// the mechanism acknowledges it. A product mechanism that never acknowledges turns the
// transaction into a full refund. A coin mechanism that never acknowledges parks the
// block in a sticky fault until reset.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous reset, active low
//   vend_valid   transaction request, credit valid
//   vend_ready   idle, transaction accepted on vend_valid
//   credit       inserted credit in nickels, captured on handshake
//   dime_empty   dime tube empty, pay change in nickels only
//   product_req  release product, held until product_ack
//   product_ack  product released
//   dime_out     eject one dime, held until coin_ack
//   nickel_out   eject one nickel, held until coin_ack
//   coin_ack     coin ejected
//   done         one-cycle pulse at transaction end
//   refund       with done: product not released, full credit returned
//   fault        sticky coin-mechanism timeout
//
// state  | meaning
// IDLE   | waiting for a transaction, vend_ready high
// VEND   | product_req held, waiting for product_ack or timeout
// CHANGE | one-cycle decision on the next coin (or finish)
// DIME   | dime_out held, waiting for coin_ack or timeout
// NICKEL | nickel_out held, waiting for coin_ack or timeout
// DONE   | done pulse, refund reports whether product was withheld
// FAULT  | coin mechanism dead, everything off until reset

module vend_dispenser #(
    parameter int CREDIT_W = 6,
    parameter int PRICE    = 3,
    parameter int TIMEOUT  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                vend_valid,
    output logic                vend_ready,
    input  logic [CREDIT_W-1:0] credit,
    input  logic                dime_empty,
    output logic                product_req,
    input  logic                product_ack,
    output logic                dime_out,
    output logic                nickel_out,
    input  logic                coin_ack,
    output logic                done,
    output logic                refund,
    output logic                fault
);

    localparam int                  TMR_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0]    TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [CREDIT_W-1:0] PRICE_C  = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] ONE_C    = CREDIT_W'(1);
    localparam logic [CREDIT_W-1:0] TWO_C    = CREDIT_W'(2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_VEND,
        S_CHANGE,
        S_DIME,
        S_NICKEL,
        S_DONE,
        S_FAULT
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [CREDIT_W-1:0] remaining_q;
    logic [CREDIT_W-1:0] credit_q;
    logic                refund_q;
    logic [TMR_W-1:0]    timer_q;

    logic handshake;
    logic tmr_last;
    logic waiting;

    assign handshake = vend_valid && (state_q == S_IDLE);
    assign tmr_last  = (timer_q == TMR_LAST);
    assign waiting   = (state_q == S_VEND) || (state_q == S_DIME) || (state_q == S_NICKEL);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; an ack in the last timer cycle still wins over the timeout
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (handshake) begin
                    state_d = (credit >= PRICE_C) ? S_VEND : S_CHANGE;
                end
            end
            S_VEND: begin
                if (product_ack || tmr_last) begin
                    state_d = S_CHANGE;
                end
            end
            S_CHANGE: begin
                if (remaining_q == '0) begin
                    state_d = S_DONE;
                end else if ((remaining_q >= TWO_C) && !dime_empty) begin
                    state_d = S_DIME;
                end else begin
                    state_d = S_NICKEL;
                end
            end
            S_DIME, S_NICKEL: begin
                if (coin_ack) begin
                    state_d = S_CHANGE;
                end else if (tmr_last) begin
                    state_d = S_FAULT;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath: balance, refund flag, captured credit and wait timer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remaining_q <= '0;
            credit_q    <= '0;
            refund_q    <= 1'b0;
            timer_q     <= '0;
        end else begin
            // Any state change restarts the timer, so every wait state starts from zero
            if (state_d != state_q) begin
                timer_q <= '0;
            end else if (waiting) begin
                timer_q <= timer_q + 1'b1;
            end else begin
                timer_q <= '0;
            end

            case (state_q)
                S_IDLE: begin
                    if (handshake) begin
                        credit_q <= credit;
                        if (credit >= PRICE_C) begin
                            remaining_q <= credit - PRICE_C;
                            refund_q    <= 1'b0;
                        end else begin
                            remaining_q <= credit;
                            refund_q    <= 1'b1;
                        end
                    end
                end
                S_VEND: begin
                    // Product never released: the whole credit goes back as change
                    if (!product_ack && tmr_last) begin
                        remaining_q <= credit_q;
                        refund_q    <= 1'b1;
                    end
                end
                S_DIME: begin
                    if (coin_ack) begin
                        remaining_q <= remaining_q - TWO_C;
                    end
                end
                S_NICKEL: begin
                    if (coin_ack) begin
                        remaining_q <= remaining_q - ONE_C;
                    end
                end
                S_DONE: begin
                    refund_q <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    // Moore outputs
    always_comb begin
        vend_ready  = 1'b0;
        product_req = 1'b0;
        dime_out    = 1'b0;
        nickel_out  = 1'b0;
        done        = 1'b0;
        refund      = 1'b0;
        fault       = 1'b0;
        case (state_q)
            S_IDLE:   vend_ready  = 1'b1;
            S_VEND:   product_req = 1'b1;
            S_DIME:   dime_out    = 1'b1;
            S_NICKEL: nickel_out  = 1'b1;
            S_DONE: begin
                done   = 1'b1;
                refund = refund_q;
            end
            S_FAULT:  fault       = 1'b1;
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_vend_dispenser.sv
// tb_vend_dispenser
// Randomized transactions against a behavioural model: the model derives, from the
// credit, the price, the product-ack delay and the dime tube state, whether the product
// is released, how long product_req is held, the refund flag and the exact coin sequence.
// Responders drive acks with random delays and inject stray acks that must be ignored.

module tb_vend_dispenser;

    localparam int CREDIT_W = 6;
    localparam int PRICE    = 3;
    localparam int TIMEOUT  = 16;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                vend_valid = 1'b0;
    logic [CREDIT_W-1:0] credit = '0;
    logic                dime_empty = 1'b0;
    logic                product_ack = 1'b0;
    logic                coin_ack = 1'b0;
    logic                vend_ready;
    logic                product_req;
    logic                dime_out;
    logic                nickel_out;
    logic                done;
    logic                refund;
    logic                fault;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    vend_dispenser #(
        .CREDIT_W (CREDIT_W),
        .PRICE    (PRICE),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .vend_valid  (vend_valid),
        .vend_ready  (vend_ready),
        .credit      (credit),
        .dime_empty  (dime_empty),
        .product_req (product_req),
        .product_ack (product_ack),
        .dime_out    (dime_out),
        .nickel_out  (nickel_out),
        .coin_ack    (coin_ack),
        .done        (done),
        .refund      (refund),
        .fault       (fault)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int outs_vec();
        return int'({vend_ready, product_req, dime_out, nickel_out, done, refund, fault});
    endfunction

    // One transaction. pd = cycles of product_req before product_ack (>= TIMEOUT: never).
    // hang = coin mechanism never acknowledges, a fault is expected instead of done.
    task automatic run_txn(input int c, input bit de, input int pd, input bit hang);
        int  exp_coins[$];
        int  coins[$];
        int  chg, nd, nn, exp_pcnt;
        bit  exp_rel;
        int  pcnt, ccnt, cdel, hcnt, cyc;
        bit  finished, faulted, rel, ref_seen;

        exp_rel  = (c >= PRICE) && (pd < TIMEOUT);
        chg      = exp_rel ? c - PRICE : c;
        nd       = de ? 0 : chg / 2;
        nn       = chg - 2 * nd;
        for (int i = 0; i < nd; i++) exp_coins.push_back(2);
        for (int i = 0; i < nn; i++) exp_coins.push_back(1);
        exp_pcnt = (c < PRICE) ? 0 : ((pd < TIMEOUT) ? pd + 1 : TIMEOUT);

        pcnt = 0; ccnt = 0; cdel = 0; hcnt = 0; cyc = 0;
        finished = 0; faulted = 0; rel = 0; ref_seen = 0;

        @(negedge clk);
        chk("ready_idle", int'(vend_ready), 1);
        vend_valid = 1'b1;
        credit     = CREDIT_W'(c);
        dime_empty = de;

        while (!finished && cyc < 400) begin
            @(negedge clk);
            cyc++;
            vend_valid  = ($urandom_range(0, 3) == 0);
            credit      = CREDIT_W'($urandom);
            product_ack = 1'b0;
            coin_ack    = 1'b0;
            chk("busy_ready", int'(vend_ready), 0);
            chk("one_actuator", int'((int'(product_req) + int'(dime_out) + int'(nickel_out)) <= 1), 1);
            if (product_req) begin
                coin_ack = ($urandom_range(0, 1) == 1);
                if (pcnt == pd) begin
                    product_ack = 1'b1;
                    rel = 1;
                end
                pcnt++;
            end
            if (dime_out || nickel_out) begin
                product_ack = ($urandom_range(0, 1) == 1);
                hcnt++;
                if (ccnt == 0) cdel = hang ? 1000 : int'($urandom_range(0, 4));
                if (ccnt == cdel) begin
                    coin_ack = 1'b1;
                    coins.push_back(dime_out ? 2 : 1);
                    ccnt = 0;
                end else begin
                    ccnt++;
                end
            end
            if (done) begin
                finished = 1;
                ref_seen = refund;
            end
            if (fault) begin
                finished = 1;
                faulted  = 1;
            end
        end
        vend_valid  = 1'b0;
        product_ack = 1'b0;
        coin_ack    = 1'b0;

        if (!finished) chk("txn_timeout", 0, 1);
        if (hang) begin
            chk("fault_seen", int'(faulted), 1);
            chk("fault_hold_cycles", hcnt, TIMEOUT);
            chk("fault_outs", outs_vec(), 1);
        end else begin
            chk("no_fault", int'(faulted), 0);
            chk("refund", int'(ref_seen), int'(!exp_rel));
            chk("product_cycles", pcnt, exp_pcnt);
            chk("released", int'(rel), int'(exp_rel));
            chk("coin_count", coins.size(), exp_coins.size());
            if (coins.size() == exp_coins.size()) begin
                for (int i = 0; i < coins.size(); i++) chk("coin_kind", coins[i], exp_coins[i]);
            end
        end
    endtask

    initial begin
        int c, pd;
        bit de;

        #1;
        chk("reset_outs", outs_vec(), 7'b1000000);
        @(negedge clk);
        rst_n = 1'b1;

        // exact price, no change
        run_txn(3, 0, 2, 0);
        // 30c: product, dime, nickel
        run_txn(6, 0, 1, 0);
        // under price: one dime back, refund
        run_txn(2, 0, 0, 0);
        // dime tube empty: two nickels
        run_txn(5, 1, 0, 0);
        // product never acked: full refund as two dimes
        run_txn(4, 0, 100, 0);
        // ack on the last timer cycle wins; one cycle later loses
        run_txn(7, 0, TIMEOUT - 1, 0);
        run_txn(5, 0, TIMEOUT, 0);
        // zero credit: straight to done with refund
        run_txn(0, 0, 0, 0);

        for (int n = 0; n < 40; n++) begin
            c  = int'($urandom_range(0, 14));
            de = ($urandom_range(0, 2) == 0);
            pd = ($urandom_range(0, 5) == 0) ? int'($urandom_range(TIMEOUT - 2, TIMEOUT + 2))
                                             : int'($urandom_range(0, 7));
            run_txn(c, de, pd, 0);
        end

        // dead coin mechanism -> sticky fault
        run_txn(2, 0, 0, 1);
        vend_valid = 1'b1;
        credit     = CREDIT_W'(5);
        repeat (4) @(negedge clk);
        chk("fault_sticky", outs_vec(), 1);
        vend_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("fault_reset", outs_vec(), 7'b1000000);
        @(negedge clk);
        rst_n = 1'b1;

        // reset in the middle of a dime eject
        @(negedge clk);
        vend_valid = 1'b1;
        credit     = CREDIT_W'(2);
        dime_empty = 1'b0;
        @(negedge clk);
        vend_valid = 1'b0;
        @(negedge clk);
        chk("mid_dime", int'(dime_out), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_dime_reset", outs_vec(), 7'b1000000);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("no_resume", outs_vec(), 7'b1000000);
        end
        run_txn(4, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
